// File: rtl/multi_voice_tracker_if.sv
// Note-load handshake bundle for the multi-voice tracker.
// The master drives a note request; the tracker answers with note_ready.
interface multi_voice_tracker_if #(
    parameter int NCH  = 4,
    parameter int PW   = 16,
    parameter int VOLW = 4
) ();
    localparam int CW = $clog2(NCH);

    logic            note_valid;
    logic            note_ready;
    logic [CW-1:0]   note_ch;
    logic [PW-1:0]   note_inc;
    logic [1:0]      note_wave;
    logic [VOLW-1:0] note_vol;
    logic [1:0]      note_eff;

    modport master (
        output note_valid, note_ch, note_inc,
        output note_wave, note_vol, note_eff,
        input  note_ready
    );

    modport slave (
        input  note_valid, note_ch, note_inc,
        input  note_wave, note_vol, note_eff,
        output note_ready
    );
endinterface

// File: rtl/multi_voice_tracker.sv
// Time-multiplexed wavetable voice mixer: one voice per ACCUM cycle,
// saturated sum published in OUTPUT, with per-voice fade effects.
module multi_voice_tracker #(
    parameter int NCH      = 4,
    parameter int PW       = 16,
    parameter int VOLW     = 4,
    parameter int FADE_DIV = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_en,
    multi_voice_tracker_if.slave note,
    output logic [7:0]          sample_out,
    output logic                sample_valid,
    output logic [NCH-1:0]      active
);
    localparam int CW  = $clog2(NCH);
    localparam int AW  = 8 + $clog2(NCH) + 1;
    localparam int PSW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t state_q, state_d;
    logic start, acc_en, out_en, last, load, step;

    logic [CW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   acc_q, acc_d, acc_sum;
    logic [PW-1:0]   phase_q [NCH];
    logic [PW-1:0]   phase_d [NCH];
    logic [PW-1:0]   inc_q   [NCH];
    logic [PW-1:0]   inc_d   [NCH];
    logic [1:0]      wave_q  [NCH];
    logic [1:0]      wave_d  [NCH];
    logic [1:0]      eff_q   [NCH];
    logic [1:0]      eff_d   [NCH];
    logic [VOLW-1:0] tgt_q   [NCH];
    logic [VOLW-1:0] tgt_d   [NCH];
    logic [VOLW-1:0] cur_q   [NCH];
    logic [VOLW-1:0] cur_d   [NCH];
    logic [NCH-1:0]  act_q, act_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [PSW-1:0]  presc_q, presc_d;
    logic [7:0]      out_q, out_d;
    logic            valid_q, valid_d;

    logic [8:0]        tri_p;
    logic [7:0]        w;
    logic [8+VOLW-1:0] prod;
    logic [7:0]        contrib;

    assign last = (idx_q == CW'(NCH - 1));
    assign load = note.note_valid && note.note_ready;
    assign step = out_en && (presc_q == PSW'(FADE_DIV - 1));

    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign active       = act_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: one ACCUM cycle per voice, then a single OUTPUT
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tick_en) state_d = ACCUM;
            ACCUM:   if (last) state_d = OUTPUT;
            OUTPUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: loads only in IDLE, ticks elsewhere are dropped
    always_comb begin
        note.note_ready = (state_q == IDLE);
        start           = (state_q == IDLE) && tick_en;
        acc_en          = (state_q == ACCUM);
        out_en          = (state_q == OUTPUT);
    end

    // Wave value of the current voice and its volume-scaled share
    always_comb begin
        tri_p = phase_q[idx_q][PW-1:PW-9];
        unique case (wave_q[idx_q])
            2'd0: w = phase_q[idx_q][PW-1] ? 8'hFF : 8'h00;
            2'd1: w = phase_q[idx_q][PW-1:PW-8];
            2'd2: w = tri_p[8] ? ~tri_p[7:0] : tri_p[7:0];
            2'd3: w = lfsr_q[7:0];
        endcase
        prod    = {{VOLW{1'b0}}, w} * {8'b0, cur_q[idx_q]};
        contrib = act_q[idx_q] ? 8'(prod >> VOLW) : 8'd0;
    end

    // Voice loads, accumulation, noise advance and fade stepping
    always_comb begin
        phase_d = phase_q;
        inc_d   = inc_q;
        wave_d  = wave_q;
        eff_d   = eff_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        act_d   = act_q;
        lfsr_d  = lfsr_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = 1'b0;
        acc_sum = acc_q + AW'(contrib);

        if (load) begin
            if (note.note_eff == 2'd3) begin
                act_d[note.note_ch] = 1'b0;
            end else begin
                inc_d[note.note_ch]   = note.note_inc;
                wave_d[note.note_ch]  = note.note_wave;
                tgt_d[note.note_ch]   = note.note_vol;
                eff_d[note.note_ch]   = note.note_eff;
                phase_d[note.note_ch] = '0;
                act_d[note.note_ch]   = 1'b1;
                cur_d[note.note_ch]   =
                    (note.note_eff == 2'd1) ? '0 : note.note_vol;
            end
        end

        if (start) begin
            idx_d = '0;
            acc_d = '0;
        end

        if (acc_en) begin
            acc_d = acc_sum;
            idx_d = idx_q + CW'(1);
            if (act_q[idx_q])
                phase_d[idx_q] = phase_q[idx_q] + inc_q[idx_q];
            if (last) begin
                valid_d = 1'b1;
                out_d   = (acc_sum > AW'(255)) ? 8'hFF : acc_sum[7:0];
            end
        end

        if (out_en) begin
            lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                       lfsr_q[15:1]};
            presc_d = step ? '0 : presc_q + PSW'(1);
        end

        if (step) begin
            for (int i = 0; i < NCH; i++) begin
                if (act_q[i] && eff_q[i] == 2'd1) begin
                    if (cur_q[i] != tgt_q[i])
                        cur_d[i] = cur_q[i] + VOLW'(1);
                    if (cur_q[i] == tgt_q[i] ||
                        cur_q[i] + VOLW'(1) == tgt_q[i])
                        eff_d[i] = 2'd0;
                end else if (act_q[i] && eff_q[i] == 2'd2) begin
                    if (cur_q[i] != '0)
                        cur_d[i] = cur_q[i] - VOLW'(1);
                    if (cur_q[i] <= VOLW'(1))
                        act_d[i] = 1'b0;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
                wave_q[i]  <= '0;
                eff_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cur_q[i]   <= '0;
            end
            act_q   <= '0;
            lfsr_q  <= SEED;
            presc_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            inc_q   <= inc_d;
            wave_q  <= wave_d;
            eff_q   <= eff_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            act_q   <= act_d;
            lfsr_q  <= lfsr_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end
endmodule
